// File: rtl/sodor3_imem_feeder.sv
// sodor3_imem_feeder
// Instruction-memory response stage for the sodor3 core/model pair. The bench
// pushes instructions into a small FIFO; the feeder hands them to the core
// whenever it requests a fetch. Shift immediates are sanitized, non-OP-IMM
// words are optionally replaced by a NOP, and NOPs are inserted during reset,
// warm-up and starvation. While the core is not requesting, the last
// presented word is held stable.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_instr, in_valid   instruction push from the bench
//   in_ready             FIFO accepts a push this cycle
//   imem_req_valid/addr  core fetch request and address
//   imem_resp_data       combinational instruction to core and model
//   issued_count         saturating count of popped (issued) words
//   bubble_count         saturating count of requested NOP bubbles
//   last_issue_addr      fetch address captured at the most recent pop
//   fifo_level           current FIFO occupancy
module sodor3_imem_feeder #(
    parameter int          DEPTH      = 4,
    parameter int          WARMUP     = 2,
    parameter logic [31:0] NOP        = 32'h00000013,
    parameter int          ITYPE_ONLY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     imem_req_valid,
    input  logic [31:0]              imem_req_addr,
    output logic [31:0]              imem_resp_data,
    output logic [15:0]              issued_count,
    output logic [15:0]              bubble_count,
    output logic [31:0]              last_issue_addr,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [6:0]    OP_IMM    = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   warm_q, warm_d;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [31:0]     hold_q;
    logic [15:0]     issued_q, bubble_q;
    logic [31:0]     last_addr_q;

    logic            full, empty, push, pop, bubble;
    logic [31:0]     head_word;

    // Shift immediates keep only the shamt (and the srai bit for funct3=5);
    // anything that is not OP-IMM becomes a bubble when ITYPE_ONLY is set.
    function automatic logic [31:0] sanitize(input logic [31:0] w);
        logic [31:0] r;
        r = w;
        if (w[6:0] == OP_IMM) begin
            if (w[14:12] == 3'd1) begin
                r[31:20] = w[31:20] & 12'h01F;
            end else if (w[14:12] == 3'd5) begin
                r[31:20] = w[31:20] & 12'h41F;
            end
        end else if (ITYPE_ONLY != 0) begin
            r = NOP;
        end
        return r;
    endfunction

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    // A full FIFO refuses pushes even when the same cycle pops.
    assign in_ready  = (state_q != IDLE) && !full;
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == RUN) && imem_req_valid && !empty;
    assign bubble    = imem_req_valid && ((state_q != RUN) || empty);
    assign head_word = sanitize(mem[rd_ptr_q]);

    always_comb begin
        imem_resp_data = hold_q;
        if (reset) begin
            imem_resp_data = NOP;
        end else if (imem_req_valid) begin
            imem_resp_data = pop ? head_word : NOP;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        case (state_q)
            IDLE: begin
                warm_d  = '0;
                state_d = (WARMUP == 0) ? RUN : WARM;
            end
            WARM: begin
                if (warm_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Storage has no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            warm_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= NOP;
            issued_q    <= '0;
            bubble_q    <= '0;
            last_addr_q <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            hold_q  <= imem_resp_data;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                last_addr_q <= imem_req_addr;
                if (issued_q != 16'hFFFF) begin
                    issued_q <= issued_q + 16'd1;
                end
            end
            if (bubble && (bubble_q != 16'hFFFF)) begin
                bubble_q <= bubble_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign issued_count    = issued_q;
    assign bubble_count    = bubble_q;
    assign last_issue_addr = last_addr_q;
    assign fifo_level      = count_q;

endmodule

// File: tb/tb_sodor3_imem_feeder.sv
// Directed testbench for sodor3_imem_feeder (DEPTH=4, WARMUP=2, ITYPE_ONLY=1).
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units
// later, well before the next edge.
module tb_sodor3_imem_feeder;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] imem_resp_data;
    logic [15:0] issued_count;
    logic [15:0] bubble_count;
    logic [31:0] last_issue_addr;
    logic [2:0]  fifo_level;

    int checks = 0;
    int passes = 0;

    sodor3_imem_feeder #(
        .DEPTH      (4),
        .WARMUP     (2),
        .NOP        (32'h00000013),
        .ITYPE_ONLY (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_instr        (in_instr),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_data  (imem_resp_data),
        .issued_count    (issued_count),
        .bubble_count    (bubble_count),
        .last_issue_addr (last_issue_addr),
        .fifo_level      (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Settle combinational outputs after input changes.
    task automatic settle();
        #2;
    endtask

    // Advance one cycle, logging the transaction presented in this cycle.
    task automatic tick();
        $display("t=%0t rst=%0b push=%0b instr=%h req=%0b addr=%h resp=%h lvl=%0d",
                 $time, reset, in_valid && in_ready, in_instr, imem_req_valid,
                 imem_req_addr, imem_resp_data, fifo_level);
        @(posedge clk);
        #1;
    endtask

    // Reset, warm-up and the first issued word.
    task automatic test_reset_warmup();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0;
        imem_req_valid = 1'b1; imem_req_addr = 32'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (imem_resp_data !== NOP) $display("FAIL reset_out%0d got %h need %h", i, imem_resp_data, NOP);
            else passes++;
            tick();
        end
        // First cycle out of reset: FSM is still IDLE; request kept low here.
        reset = 1'b0; imem_req_valid = 1'b0;
        settle();
        checks++;
        if (in_ready !== 1'b0) $display("FAIL idle_in_ready got %b need 0", in_ready);
        else passes++;
        checks++;
        if (fifo_level !== 3'd0) $display("FAIL idle_level got %0d need 0", fifo_level);
        else passes++;
        checks++;
        if (issued_count !== 16'd0 || bubble_count !== 16'd0)
            $display("FAIL idle_counters got %0d/%0d need 0/0", issued_count, bubble_count);
        else passes++;
        checks++;
        if (last_issue_addr !== 32'd0) $display("FAIL idle_addr got %h need 0", last_issue_addr);
        else passes++;
        checks++;
        if (imem_resp_data !== NOP) $display("FAIL idle_out got %h need %h", imem_resp_data, NOP);
        else passes++;
        tick();
        // First WARM cycle: push and request.
        imem_req_valid = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093;
        settle();
        checks++;
        if (in_ready !== 1'b1) $display("FAIL warm_in_ready got %b need 1", in_ready);
        else passes++;
        checks++;
        if (imem_resp_data !== NOP) $display("FAIL warm0_out got %h need %h", imem_resp_data, NOP);
        else passes++;
        tick();
        in_valid = 1'b0;
        settle();
        checks++;
        if (imem_resp_data !== NOP || fifo_level !== 3'd1)
            $display("FAIL warm1_out got %h lvl %0d need %h lvl 1", imem_resp_data, fifo_level, NOP);
        else passes++;
        tick();
        imem_req_addr = 32'h100;
        settle();
        checks++;
        if (imem_resp_data !== 32'h00500093) $display("FAIL first_issue got %h need 00500093", imem_resp_data);
        else passes++;
        tick();
        imem_req_valid = 1'b0;
        settle();
        checks++;
        if (issued_count !== 16'd1 || bubble_count !== 16'd2)
            $display("FAIL warm_counters got %0d/%0d need 1/2", issued_count, bubble_count);
        else passes++;
        checks++;
        if (last_issue_addr !== 32'h100 || fifo_level !== 3'd0)
            $display("FAIL warm_addr_lvl got %h/%0d need 100/0", last_issue_addr, fifo_level);
        else passes++;
        checks++;
        if (imem_resp_data !== 32'h00500093) $display("FAIL warm_hold got %h need 00500093", imem_resp_data);
        else passes++;
    endtask

    task automatic test_sanitize();
        in_valid = 1'b1; in_instr = 32'hFFF09093; imem_req_valid = 1'b0;
        tick();
        in_valid = 1'b0; imem_req_valid = 1'b1; imem_req_addr = 32'h104;
        settle();
        checks++;
        if (imem_resp_data !== 32'h01F09093) $display("FAIL slli_sanitize got %h need 01F09093", imem_resp_data);
        else passes++;
        tick();
        in_valid = 1'b1; in_instr = 32'hFFF0D093; imem_req_valid = 1'b0;
        settle();
        checks++;
        if (imem_resp_data !== 32'h01F09093) $display("FAIL slli_hold got %h need 01F09093", imem_resp_data);
        else passes++;
        tick();
        in_valid = 1'b0; imem_req_valid = 1'b1; imem_req_addr = 32'h108;
        settle();
        checks++;
        if (imem_resp_data !== 32'h41F0D093) $display("FAIL srai_sanitize got %h need 41F0D093", imem_resp_data);
        else passes++;
        tick();
        imem_req_valid = 1'b0;
        settle();
        checks++;
        if (issued_count !== 16'd3 || bubble_count !== 16'd2)
            $display("FAIL sanitize_counters got %0d/%0d need 3/2", issued_count, bubble_count);
        else passes++;
    endtask

    task automatic test_itype_only();
        in_valid = 1'b1; in_instr = 32'h00208033; imem_req_valid = 1'b0;
        tick();
        in_valid = 1'b0; imem_req_valid = 1'b1; imem_req_addr = 32'h10C;
        settle();
        checks++;
        if (imem_resp_data !== NOP) $display("FAIL rtype_nop got %h need %h", imem_resp_data, NOP);
        else passes++;
        tick();
        imem_req_valid = 1'b0;
        settle();
        checks++;
        if (issued_count !== 16'd4 || bubble_count !== 16'd2)
            $display("FAIL rtype_counters got %0d/%0d need 4/2", issued_count, bubble_count);
        else passes++;
    endtask

    task automatic test_fill();
        logic [31:0] words [4];
        words[0] = 32'h00100093; words[1] = 32'h00200093;
        words[2] = 32'h00300093; words[3] = 32'h00400093;
        imem_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = words[i];
            settle();
            checks++;
            if (in_ready !== 1'b1) $display("FAIL fill_ready%0d got %b need 1", i, in_ready);
            else passes++;
            tick();
        end
        // Full, request one word while still offering a push.
        in_instr = 32'h00600093; imem_req_valid = 1'b1; imem_req_addr = 32'h110;
        settle();
        checks++;
        if (in_ready !== 1'b0 || fifo_level !== 3'd4)
            $display("FAIL full_state got ready %b lvl %0d need 0/4", in_ready, fifo_level);
        else passes++;
        checks++;
        if (imem_resp_data !== 32'h00100093) $display("FAIL full_pop got %h need 00100093", imem_resp_data);
        else passes++;
        tick();
        in_valid = 1'b0; imem_req_valid = 1'b0;
        settle();
        checks++;
        if (fifo_level !== 3'd3 || in_ready !== 1'b1)
            $display("FAIL after_pop got lvl %0d ready %b need 3/1", fifo_level, in_ready);
        else passes++;
        checks++;
        if (imem_resp_data !== 32'h00100093 || issued_count !== 16'd5)
            $display("FAIL after_pop_hold got %h/%0d need 00100093/5", imem_resp_data, issued_count);
        else passes++;
    endtask

    task automatic test_reset_flush();
        reset = 1'b1; imem_req_valid = 1'b1;
        settle();
        checks++;
        if (imem_resp_data !== NOP) $display("FAIL flush_rst_out got %h need %h", imem_resp_data, NOP);
        else passes++;
        tick();
        reset = 1'b0; imem_req_valid = 1'b0;
        settle();
        checks++;
        if (fifo_level !== 3'd0 || in_ready !== 1'b0)
            $display("FAIL flush_lvl got %0d ready %b need 0/0", fifo_level, in_ready);
        else passes++;
        checks++;
        if (issued_count !== 16'd0 || bubble_count !== 16'd0 || last_issue_addr !== 32'd0)
            $display("FAIL flush_counters got %0d/%0d/%h need 0/0/0", issued_count, bubble_count, last_issue_addr);
        else passes++;
        checks++;
        if (imem_resp_data !== NOP) $display("FAIL flush_out got %h need %h", imem_resp_data, NOP);
        else passes++;
        // IDLE -> WARM -> WARM -> RUN
        for (int i = 0; i < 3; i++) tick();
        imem_req_valid = 1'b1; imem_req_addr = 32'h1F0;
        settle();
        checks++;
        if (imem_resp_data !== NOP || fifo_level !== 3'd0)
            $display("FAIL flush_stale got %h lvl %0d need %h/0", imem_resp_data, fifo_level, NOP);
        else passes++;
        tick();
        imem_req_valid = 1'b0;
        settle();
        checks++;
        if (issued_count !== 16'd0 || bubble_count !== 16'd1)
            $display("FAIL flush_bubble got %0d/%0d need 0/1", issued_count, bubble_count);
        else passes++;
    endtask

    task automatic test_hold();
        in_valid = 1'b1; in_instr = 32'h00A00113; imem_req_valid = 1'b0;
        tick();
        in_valid = 1'b0; imem_req_valid = 1'b1; imem_req_addr = 32'h200;
        settle();
        checks++;
        if (imem_resp_data !== 32'h00A00113) $display("FAIL hold_issue got %h need 00A00113", imem_resp_data);
        else passes++;
        tick();
        for (int i = 0; i < 3; i++) begin
            imem_req_valid = 1'b0; imem_req_addr = 32'h300 + 32'(i);
            settle();
            checks++;
            if (imem_resp_data !== 32'h00A00113) $display("FAIL hold_out%0d got %h need 00A00113", i, imem_resp_data);
            else passes++;
            checks++;
            if (issued_count !== 16'd1 || bubble_count !== 16'd1 || last_issue_addr !== 32'h200)
                $display("FAIL hold_cnt%0d got %0d/%0d/%h need 1/1/200", i, issued_count, bubble_count, last_issue_addr);
            else passes++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = 32'h00700093; imem_req_valid = 1'b0;
        tick();
        in_instr = 32'h00800093; imem_req_valid = 1'b1; imem_req_addr = 32'h400;
        settle();
        checks++;
        if (imem_resp_data !== 32'h00700093 || in_ready !== 1'b1)
            $display("FAIL b2b_first got %h ready %b need 00700093/1", imem_resp_data, in_ready);
        else passes++;
        tick();
        in_valid = 1'b0; imem_req_valid = 1'b0;
        settle();
        checks++;
        if (fifo_level !== 3'd1) $display("FAIL b2b_level got %0d need 1", fifo_level);
        else passes++;
        imem_req_valid = 1'b1; imem_req_addr = 32'h404;
        settle();
        checks++;
        if (imem_resp_data !== 32'h00800093) $display("FAIL b2b_second got %h need 00800093", imem_resp_data);
        else passes++;
        tick();
        imem_req_valid = 1'b0;
        settle();
        checks++;
        if (fifo_level !== 3'd0 || issued_count !== 16'd3 || last_issue_addr !== 32'h404)
            $display("FAIL b2b_end got %0d/%0d/%h need 0/3/404", fifo_level, issued_count, last_issue_addr);
        else passes++;
    endtask

    initial begin
        test_reset_warmup();
        test_sanitize();
        test_itype_only();
        test_fill();
        test_reset_flush();
        test_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
